// File: rtl/clock_div_prog_if.sv
// clock_div_prog_if
// -----------------
// Groups the control, reload handshake and output signals of clock_div_prog.
// The system clock and reset are not part of the bundle; they stay plain
// ports on the divider.
//
// Signals
//   enable       : counter advance enable (master -> slave)
//   div_in       : proposed divisor (master -> slave)
//   load_valid   : load request for div_in (master -> slave)
//   load_ready   : divider can accept a load (slave -> master)
//   div_clock    : divided square wave (slave -> master)
//   tick         : one-cycle strobe at each div_clock rising edge (slave -> master)
//   cur_div      : divisor currently in force (slave -> master)
//   period_count : wrap counter, only with CLKDIV_PERIOD_COUNT_EN defined
//
// Optional feature macro: CLKDIV_PERIOD_COUNT_EN
interface clock_div_prog_if #(
    parameter int WIDTH = 24
);
    logic             enable;
    logic [WIDTH-1:0] div_in;
    logic             load_valid;
    logic             load_ready;
    logic             div_clock;
    logic             tick;
    logic [WIDTH-1:0] cur_div;
`ifdef CLKDIV_PERIOD_COUNT_EN
    logic [15:0]      period_count;

    modport master (
        output enable, div_in, load_valid,
        input  load_ready, div_clock, tick, cur_div, period_count
    );

    modport slave (
        input  enable, div_in, load_valid,
        output load_ready, div_clock, tick, cur_div, period_count
    );
`else
    modport master (
        output enable, div_in, load_valid,
        input  load_ready, div_clock, tick, cur_div
    );

    modport slave (
        input  enable, div_in, load_valid,
        output load_ready, div_clock, tick, cur_div
    );
`endif
endinterface

// File: rtl/clock_div_prog.sv
// clock_div_prog
// --------------
// Runtime-programmable synchronous clock divider. A single WIDTH-bit counter
// produces a near-50% duty div_clock (high phase ceil(N/2) cycles) and a
// one-cycle tick strobe that consumers use as a clock enable. Everything runs
// on the rising edge of the system clock; no derived clocks are generated.
// A new divisor is accepted through a valid/ready handshake and only takes
// effect on a period boundary (or immediately while the counter is stopped).
//
// Parameters
//   WIDTH       : divisor and counter width
//   DEFAULT_DIV : divisor loaded at reset, 2 <= DEFAULT_DIV < 2**WIDTH
//
// Ports
//   clock : system clock, rising edge
//   reset : synchronous, active-low reset
//   bus   : clock_div_prog_if slave modport (enable, div_in, load_valid,
//           load_ready, div_clock, tick, cur_div [, period_count])
//
// Optional feature macro: CLKDIV_PERIOD_COUNT_EN adds a 16-bit count of
// completed periods on bus.period_count.
module clock_div_prog #(
    parameter int WIDTH       = 24,
    parameter int DEFAULT_DIV = 100000
) (
    input  logic              clock,
    input  logic              reset,
    clock_div_prog_if.slave   bus
);

    localparam logic [WIDTH-1:0] DEFAULT_DIV_W = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cur_div_q;
    logic [WIDTH-1:0] pend_div;
    logic             pend;
    logic             div_clock_q;
    logic             tick_q;

    logic [WIDTH-1:0] last_cnt;
    logic [WIDTH-1:0] half_last;
    logic             wrap;
    logic             load_fire;
    logic [WIDTH-1:0] capture_div;

    // half_last is ceil(N/2)-1, the count at which the high phase ends.
    // Divisors 0 and 1 would make the counter meaningless, so they are
    // raised to 2 when captured.
    always_comb begin
        last_cnt    = cur_div_q - WIDTH'(1);
        half_last   = last_cnt >> 1;
        wrap        = bus.enable && (cnt == last_cnt);
        load_fire   = bus.load_valid && !pend;
        capture_div = (bus.div_in[WIDTH-1:1] == '0) ? WIDTH'(2) : bus.div_in;
    end

    // Counter and waveform generation. A pending divisor is swapped in only
    // when the counter returns to zero, so a shrinking divisor can never
    // leave the counter beyond the new last count. While stopped, a pending
    // divisor is applied at once and the waveform restarts from count 0.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt         <= '0;
            cur_div_q   <= DEFAULT_DIV_W;
            div_clock_q <= 1'b0;
            tick_q      <= 1'b0;
        end else if (!bus.enable) begin
            tick_q <= 1'b0;
            if (pend) begin
                cur_div_q   <= pend_div;
                cnt         <= '0;
                div_clock_q <= 1'b0;
            end
        end else begin
            tick_q <= wrap;
            if (wrap) begin
                cnt         <= '0;
                div_clock_q <= 1'b1;
                if (pend) begin
                    cur_div_q <= pend_div;
                end
            end else begin
                cnt <= cnt + WIDTH'(1);
                if (cnt == half_last) begin
                    div_clock_q <= 1'b0;
                end
            end
        end
    end

    // Reload handshake. A transfer can only happen with nothing pending, so
    // it never collides with the edge that consumes the pending value; a
    // value captured on a wrap edge therefore waits for the following wrap.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pend     <= 1'b0;
            pend_div <= DEFAULT_DIV_W;
        end else if (load_fire) begin
            pend     <= 1'b1;
            pend_div <= capture_div;
        end else if (pend && (!bus.enable || wrap)) begin
            pend <= 1'b0;
        end
    end

`ifdef CLKDIV_PERIOD_COUNT_EN
    logic [15:0] period_count_q;

    // Completed-period counter; rolls over naturally at 16 bits.
    always_ff @(posedge clock) begin
        if (!reset) begin
            period_count_q <= '0;
        end else if (wrap) begin
            period_count_q <= period_count_q + 16'd1;
        end
    end

    assign bus.period_count = period_count_q;
`endif

    assign bus.load_ready = !pend;
    assign bus.div_clock  = div_clock_q;
    assign bus.tick       = tick_q;
    assign bus.cur_div    = cur_div_q;

endmodule

// File: tb/tb_clock_div_prog.sv
// tb_clock_div_prog
// -----------------
// Self-checking bench for clock_div_prog with WIDTH=8 and DEFAULT_DIV=4.
// Expected per-cycle output words {div_clock, tick, cur_div, load_ready} are
// queued when each scenario is set up and popped one per clock edge.
// Optional feature macro: CLKDIV_PERIOD_COUNT_EN
module tb_clock_div_prog;

    localparam int TW = 8;

    typedef logic [TW+2:0] exp_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t exp_v;
    exp_t act_v;

    clock_div_prog_if #(.WIDTH(TW)) bus ();

    clock_div_prog #(
        .WIDTH(TW),
        .DEFAULT_DIV(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Queue count identical words with tick low.
    function automatic void push_flat(int count, logic dc, int cd, logic rdy);
        for (int k = 0; k < count; k++) begin
            sb.push_back({dc, 1'b0, TW'(cd), rdy});
        end
    endfunction

    // Queue phases lo..hi of a period of length n: high for ceil(n/2)
    // cycles starting with the tick cycle, then low.
    function automatic void push_phases(int n, int lo, int hi, logic rdy);
        for (int p = lo; p <= hi; p++) begin
            sb.push_back({logic'(p < (n + 1) / 2), logic'(p == 0), TW'(n), rdy});
        end
    endfunction

    task automatic do_reset();
        bus.enable     = 1'b0;
        bus.load_valid = 1'b0;
        bus.div_in     = '0;
        reset          = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        bus.enable     = 1'b1;
        bus.load_valid = 1'b1;
        bus.div_in     = 8'd9;
        repeat (3) @(posedge clock);
        #1;
        act_v = {bus.div_clock, bus.tick, bus.cur_div, bus.load_ready};
        exp_v = {1'b0, 1'b0, TW'(4), 1'b1};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL reset_state got %h expected %h", act_v, exp_v);
        end
`ifdef CLKDIV_PERIOD_COUNT_EN
        checks++;
        if (bus.period_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_period_count got %0d expected 0", bus.period_count);
        end
`endif
        bus.load_valid = 1'b0;
        bus.enable     = 1'b0;
    endtask

    task automatic test_default_div();
        do_reset();
        push_flat(3, 1'b0, 4, 1'b1);
        repeat (3) push_phases(4, 0, 3, 1'b1);
        for (int i = 0; sb.size() > 0; i++) begin
            bus.enable = 1'b1;
            @(posedge clock);
            #1;
            exp_v = sb.pop_front();
            act_v = {bus.div_clock, bus.tick, bus.cur_div, bus.load_ready};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL default_div cycle %0d got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_odd_div();
        do_reset();
        bus.load_valid = 1'b1;
        bus.div_in     = 8'd5;
        @(posedge clock);
        #1;
        bus.load_valid = 1'b0;
        act_v = {bus.div_clock, bus.tick, bus.cur_div, bus.load_ready};
        exp_v = {1'b0, 1'b0, TW'(4), 1'b0};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL odd_transfer got %h expected %h", act_v, exp_v);
        end
        @(posedge clock);
        #1;
        act_v = {bus.div_clock, bus.tick, bus.cur_div, bus.load_ready};
        exp_v = {1'b0, 1'b0, TW'(5), 1'b1};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL odd_apply_stopped got %h expected %h", act_v, exp_v);
        end
        push_flat(4, 1'b0, 5, 1'b1);
        repeat (2) push_phases(5, 0, 4, 1'b1);
        for (int i = 0; sb.size() > 0; i++) begin
            bus.enable = 1'b1;
            @(posedge clock);
            #1;
            exp_v = sb.pop_front();
            act_v = {bus.div_clock, bus.tick, bus.cur_div, bus.load_ready};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL odd_div cycle %0d got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_load_mid_period();
        do_reset();
        push_flat(1, 1'b0, 4, 1'b1);
        push_flat(2, 1'b0, 4, 1'b0);
        repeat (2) push_phases(6, 0, 5, 1'b1);
        for (int i = 0; sb.size() > 0; i++) begin
            bus.enable     = 1'b1;
            bus.load_valid = (i == 1);
            bus.div_in     = 8'd6;
            @(posedge clock);
            #1;
            exp_v = sb.pop_front();
            act_v = {bus.div_clock, bus.tick, bus.cur_div, bus.load_ready};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL load_mid cycle %0d got %h expected %h", i, act_v, exp_v);
            end
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic test_pending_and_clamp();
        do_reset();
        push_flat(1, 1'b0, 4, 1'b1);
        push_flat(2, 1'b0, 4, 1'b0);
        repeat (2) push_phases(6, 0, 5, 1'b1);
        for (int i = 0; sb.size() > 0; i++) begin
            bus.enable     = 1'b1;
            bus.load_valid = (i == 1) || (i == 2);
            bus.div_in     = (i == 1) ? 8'd6 : 8'd3;
            @(posedge clock);
            #1;
            exp_v = sb.pop_front();
            act_v = {bus.div_clock, bus.tick, bus.cur_div, bus.load_ready};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL pending_ignore cycle %0d got %h expected %h", i, act_v, exp_v);
            end
        end
        bus.enable     = 1'b0;
        bus.load_valid = 1'b1;
        bus.div_in     = 8'd0;
        @(posedge clock);
        #1;
        bus.load_valid = 1'b0;
        act_v = {bus.div_clock, bus.tick, bus.cur_div, bus.load_ready};
        exp_v = {1'b0, 1'b0, TW'(6), 1'b0};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL zero_transfer got %h expected %h", act_v, exp_v);
        end
        @(posedge clock);
        #1;
        act_v = {bus.div_clock, bus.tick, bus.cur_div, bus.load_ready};
        exp_v = {1'b0, 1'b0, TW'(2), 1'b1};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL zero_clamp got %h expected %h", act_v, exp_v);
        end
        push_flat(1, 1'b0, 2, 1'b1);
        repeat (3) push_phases(2, 0, 1, 1'b1);
        for (int i = 0; sb.size() > 0; i++) begin
            bus.enable = 1'b1;
            @(posedge clock);
            #1;
            exp_v = sb.pop_front();
            act_v = {bus.div_clock, bus.tick, bus.cur_div, bus.load_ready};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL div2_run cycle %0d got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_load_on_wrap();
        do_reset();
        push_flat(3, 1'b0, 4, 1'b1);
        push_phases(4, 0, 3, 1'b0);
        repeat (2) push_phases(5, 0, 4, 1'b1);
        for (int i = 0; sb.size() > 0; i++) begin
            bus.enable     = 1'b1;
            bus.load_valid = (i == 3);
            bus.div_in     = 8'd5;
            @(posedge clock);
            #1;
            exp_v = sb.pop_front();
            act_v = {bus.div_clock, bus.tick, bus.cur_div, bus.load_ready};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL load_on_wrap cycle %0d got %h expected %h", i, act_v, exp_v);
            end
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic test_enable_freeze();
        do_reset();
        push_flat(3, 1'b0, 4, 1'b1);
        push_phases(4, 0, 1, 1'b1);
        push_flat(10, 1'b1, 4, 1'b1);
        push_phases(4, 2, 3, 1'b1);
        push_phases(4, 0, 3, 1'b1);
        for (int i = 0; sb.size() > 0; i++) begin
            bus.enable = !((i >= 5) && (i < 15));
            @(posedge clock);
            #1;
            exp_v = sb.pop_front();
            act_v = {bus.div_clock, bus.tick, bus.cur_div, bus.load_ready};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL enable_freeze cycle %0d got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_period();
        do_reset();
        push_flat(3, 1'b0, 4, 1'b1);
        push_phases(4, 0, 0, 1'b1);
        push_flat(1, 1'b1, 4, 1'b0);
        for (int i = 0; sb.size() > 0; i++) begin
            bus.enable     = 1'b1;
            bus.load_valid = (i == 4);
            bus.div_in     = 8'd6;
            @(posedge clock);
            #1;
            exp_v = sb.pop_front();
            act_v = {bus.div_clock, bus.tick, bus.cur_div, bus.load_ready};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL pre_reset cycle %0d got %h expected %h", i, act_v, exp_v);
            end
        end
        bus.load_valid = 1'b0;
        reset          = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        act_v = {bus.div_clock, bus.tick, bus.cur_div, bus.load_ready};
        exp_v = {1'b0, 1'b0, TW'(4), 1'b1};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL mid_reset_state got %h expected %h", act_v, exp_v);
        end
`ifdef CLKDIV_PERIOD_COUNT_EN
        checks++;
        if (bus.period_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_period_count got %0d expected 0", bus.period_count);
        end
`endif
        push_flat(3, 1'b0, 4, 1'b1);
        repeat (3) push_phases(4, 0, 3, 1'b1);
        for (int i = 0; sb.size() > 0; i++) begin
            bus.enable = 1'b1;
            @(posedge clock);
            #1;
            exp_v = sb.pop_front();
            act_v = {bus.div_clock, bus.tick, bus.cur_div, bus.load_ready};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL post_reset cycle %0d got %h expected %h", i, act_v, exp_v);
            end
        end
`ifdef CLKDIV_PERIOD_COUNT_EN
        checks++;
        if (bus.period_count !== 16'd3) begin
            errors++;
            $display("[TB] FAIL period_count_three got %0d expected 3", bus.period_count);
        end
`endif
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b0;
        bus.enable     = 1'b0;
        bus.load_valid = 1'b0;
        bus.div_in     = '0;
        test_reset();
        test_default_div();
        test_odd_div();
        test_load_mid_period();
        test_pending_and_clamp();
        test_load_on_wrap();
        test_enable_freeze();
        test_reset_mid_period();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_div_prog.md
# clock_div_prog

Runtime-programmable synchronous clock divider. It produces a near-50% duty `div_clock` and a one-cycle `tick` strobe from a single system clock using one WIDTH-bit counter; there are no ripple flip-flops and no derived clock domains. The divisor can be reloaded at run time through a valid/ready handshake, and a new divisor only takes effect on a period boundary. The block sits between the 100 MHz board clock and slow consumers such as display scan and debounce logic, and those consumers use `tick` as a clock enable.

## Interface
- `WIDTH`, 24: width of the divisor and the counter.
- `DEFAULT_DIV`, 100000: divisor loaded at reset. Must be ≥ 2 and < 2^WIDTH.

- `clock` input 1: the single system clock. All logic is clocked on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `enable` input 1: when high, the counter advances. When low, the counter and `div_clock` hold.
- `div_in` input WIDTH: proposed divisor.
- `load_valid` input 1: requests a load of `div_in`.
- `load_ready` output 1: high when the block can accept a load.
- `div_clock` output 1: divided square wave with period N cycles.
- `tick` output 1: one-cycle strobe, high in the same cycle as each `div_clock` rising edge.
- `cur_div` output WIDTH: the divisor N currently in force.
- `period_count` output 16: present only with `CLKDIV_PERIOD_COUNT_EN` (see Configuration).

## Operation
- State registers:
  - `cnt` (WIDTH bits)
  - `cur_div` = N
  - `pend_div` and a `pend` flag
  - `div_clock`
  - `tick`
- Reset (`reset`=0 at a clock edge) forces: `cnt`=0, `cur_div`=DEFAULT_DIV, `pend`=0, `div_clock`=0, `tick`=0, `load_ready`=1, `period_count`=0.
- Let H = ceil(N/2). Define `wrap` = `enable` & (`cnt` == N−1).
- Each edge with `enable`=1:
  - `cnt` <= `wrap` ? 0 : `cnt`+1.
  - `div_clock` <= 1 on `wrap`; <= 0 when `cnt` == H−1; otherwise it holds.
  - `tick` <= `wrap`.
- Each edge with `enable`=0: `cnt` and `div_clock` hold, and `tick` <= 0.
- Resulting waveform: `div_clock` is high for H cycles and low for N−H cycles. For odd N, the high phase is the longer one.
- Load handshake:
  - `load_ready` = !`pend`.
  - A transfer occurs on an edge where `load_valid` & `load_ready`. On that edge: `pend_div` <= `div_in` and `pend` <= 1.
  - Values 0 and 1 are clamped to 2 at capture.
  - `load_valid` with `load_ready`=0 is ignored. The source must hold `load_valid` until it sees ready.
- Applying a pending divisor:
  - With `enable`=1: applied on the next `wrap` edge. `cur_div` <= `pend_div`, `pend` <= 0, and the normal wrap actions happen. The new N governs the period that starts at that edge.
  - With `enable`=0: applied on the next edge. `cur_div` <= `pend_div`, `cnt` <= 0, `div_clock` <= 0, `pend` <= 0.
- Transfer and wrap on the same edge: the newly captured value becomes pending. It is not applied on that edge; it is applied at the following wrap.
- If `cur_div` shrinks, `cnt` is always < N at the moment of the switch, because the switch happens when `cnt` resets to 0. The counter therefore never overruns.
- Reset asserted mid-period or while a load is pending discards `cnt` and `pend`, and restores DEFAULT_DIV.

## Timing
- From reset release with `enable`=1 held: `cnt` is 1 after edge 1. The first `div_clock` rise and `tick` come after edge N, then every N edges after that.
- `tick` and `div_clock` are registered outputs; there is no combinational path from any input to them.
- `load_ready` depends only on a register.
- Load to effect (`enable`=1): between 1 and N edges after the transfer edge.
- `cur_div` updates on the same edge the new period starts.

## Configuration
- `CLKDIV_PERIOD_COUNT_EN` defined:
  - Adds output `period_count`[15:0], reset 0.
  - Increments on every edge where `wrap`=1 and wraps 65535 → 0.
  - Unaffected by divisor loads.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset then `enable`=1 with DEFAULT_DIV overridden to 4: first `tick` after edge 4. After that, `div_clock` is 1,1,0,0 repeating and `tick` pulses every 4 cycles; `cur_div`=4.
- N=5: `div_clock` is high for 3 cycles and low for 2. `tick` aligns with every rising edge; period = 5.
- Load `div_in`=6 mid-period with N=4: `load_ready` drops the cycle after the transfer. The current period finishes at 4. `cur_div`=6 at the wrap, the next period lasts 6 cycles, and `load_ready` returns to 1.
- `load_valid` while a load is pending: second value ignored. Load of `div_in`=0 with `enable`=0: `cur_div`=2 and `cnt`=0 on the next edge.
- `enable` dropped for 10 cycles mid-period: `cnt` and `div_clock` are frozen and `tick`=0. The period resumes with no lost or extra counts.
- Reset mid-period with a load pending: all outputs return to reset values and `cur_div`=DEFAULT_DIV. With `CLKDIV_PERIOD_COUNT_EN` defined, `period_count` reads 0, then 3 after three wraps.
